// File: rtl/fir_mac_pkg.sv
// rtl/fir_mac_pkg.sv - shared widths, saturation limits, FSM states and sat18 for the FIR MAC sequencer
package fir_mac_pkg;

  localparam int     DW      = 18;
  localparam int     PW      = 36;
  localparam int     SATW    = 64;
  localparam longint SAT_MAX = 131071;
  localparam longint SAT_MIN = -131072;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  function automatic logic signed [DW-1:0] sat18(input logic signed [SATW-1:0] x);
    if (x > SAT_MAX) return DW'(SAT_MAX);
    if (x < SAT_MIN) return DW'(SAT_MIN);
    return x[DW-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_rsat.sv
// rtl/fir_mac_rsat.sv - combinational round, arithmetic shift and 18-bit saturation of the accumulator
// Build option: FIR_MAC_ROUND_EN adds half an output LSB before the shift (round half up); otherwise truncates.
module fir_mac_rsat
  import fir_mac_pkg::*;
#(
  parameter int ACCW      = 42,
  parameter int OUT_SHIFT = 17
) (
  input  logic signed [ACCW-1:0] acc,
  output logic        [DW-1:0]   res
);

`ifdef FIR_MAC_ROUND_EN
  // (1 << S) >> 1 gives 2^(S-1) and collapses to 0 when S is 0
  localparam logic signed [ACCW:0] RND = ((ACCW+1)'(1) << OUT_SHIFT) >> 1;
`else
  localparam logic signed [ACCW:0] RND = '0;
`endif

  logic signed [ACCW:0]   sum;
  logic signed [ACCW:0]   shifted;
  logic signed [SATW-1:0] wide;

  assign sum     = {acc[ACCW-1], acc} + RND;
  assign shifted = sum >>> OUT_SHIFT;
  assign wide    = {{(SATW-ACCW-1){shifted[ACCW]}}, shifted};
  assign res     = sat18(wide);

endmodule

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - time-multiplexed FIR sequencer/accumulator feeding one external registered 18x18 multiplier
// Build option: FIR_MAC_ROUND_EN selects round-half-up output scaling (see fir_mac_rsat).
module fir_mac_seq
  import fir_mac_pkg::*;
#(
  parameter int NTAPS     = 16,
  parameter int OUT_SHIFT = 17,
  parameter int ACCW      = 42
) (
  input  logic                     CLK0,
  input  logic                     RST0_N,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [DW-1:0]            coef_data,
  output logic [DW-1:0]            mult_a,
  output logic [DW-1:0]            mult_b,
  input  logic [PW-1:0]            mult_p,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic                     busy
);

  localparam int            AW     = $clog2(NTAPS);
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

  state_t                 state;
  state_t                 state_next;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          k;
  logic [AW-1:0]          rd_idx;
  logic [DW-1:0]          line [NTAPS];
  logic [DW-1:0]          coef [NTAPS];
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_next;
  logic signed [ACCW-1:0] prod_ext;
  logic                   p_vld;
  logic                   p_first;
  logic                   accept;
  logic [DW-1:0]          rsat_out;

  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign rd_idx   = wr_ptr - k;
  assign prod_ext = {{(ACCW-PW){mult_p[PW-1]}}, mult_p};

  always_ff @(posedge CLK0 or negedge RST0_N) begin
    if (!RST0_N) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    mult_a     = '0;
    mult_b     = '0;
    case (state)
      IDLE:  if (accept) state_next = RUN;
      RUN: begin
        mult_a = line[rd_idx];
        mult_b = coef[k];
        if (k == K_LAST) state_next = DRAIN;
      end
      DRAIN: state_next = OUT;
      OUT:   if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready is registered so it stays low until the first edge after reset release
  always_ff @(posedge CLK0 or negedge RST0_N) begin
    if (!RST0_N) begin
      in_ready <= 1'b0;
      wr_ptr   <= '0;
      k        <= '0;
      p_vld    <= 1'b0;
      p_first  <= 1'b0;
    end else begin
      in_ready <= (state_next == IDLE);
      p_vld    <= (state == RUN);
      p_first  <= (state == RUN) && (k == '0);
      if (accept)            k <= '0;
      else if (state == RUN) k <= k + AW'(1);
      if (state == RUN && k == K_LAST) wr_ptr <= wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge CLK0 or negedge RST0_N) begin
    if (!RST0_N) begin
      for (int i = 0; i < NTAPS; i++) begin
        line[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      if (accept)            line[wr_ptr]    <= in_data;
      if (coef_we && !busy)  coef[coef_addr] <= coef_data;
    end
  end

  // The last product arrives during DRAIN, so the output is scaled from acc_next, not acc
  always_comb begin
    acc_next = p_first ? prod_ext : acc + prod_ext;
  end

  fir_mac_rsat #(
    .ACCW      (ACCW),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_rsat (
    .acc (acc_next),
    .res (rsat_out)
  );

  always_ff @(posedge CLK0 or negedge RST0_N) begin
    if (!RST0_N) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (p_vld) acc <= acc_next;
      if (state == DRAIN) begin
        out_valid <= 1'b1;
        out_data  <= rsat_out;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - self-checking bench for fir_mac_seq with a behavioural multiplier and FIR reference model
module tb_fir_mac_seq;

  localparam int NTAPS     = 16;
  localparam int OUT_SHIFT = 17;
  localparam int ACCW      = 42;
  localparam int AW        = $clog2(NTAPS);
`ifdef FIR_MAC_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  localparam longint RND_M = ROUND ? ((longint'(1) << OUT_SHIFT) >> 1) : 0;

  logic               CLK0 = 1'b0;
  logic               RST0_N;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] in_data;
  logic               coef_we;
  logic [AW-1:0]      coef_addr;
  logic signed [17:0] coef_data;
  logic [17:0]        mult_a;
  logic [17:0]        mult_b;
  logic signed [35:0] mult_p = '0;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] out_data;
  logic               busy;

  int passed = 0;
  int total  = 0;

  int hist[$];
  int mcoef[NTAPS];

  always #5 CLK0 = ~CLK0;

  // Registered multiplier, latency 1, no reset
  always @(posedge CLK0) mult_p <= $signed(mult_a) * $signed(mult_b);

  fir_mac_seq #(
    .NTAPS     (NTAPS),
    .OUT_SHIFT (OUT_SHIFT),
    .ACCW      (ACCW)
  ) dut (
    .CLK0      (CLK0),
    .RST0_N    (RST0_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // y[n] = sat(floor((sum_k x[n-k]*c[k] + rnd) / 2^OUT_SHIFT)); hist[0] is the newest sample
  function automatic longint mdl_result();
    longint s = 0;
    for (int i = 0; i < NTAPS; i++)
      if (i < hist.size()) s += longint'(hist[i]) * longint'(mcoef[i]);
    s = (s + RND_M) >>> OUT_SHIFT;
    if (s > 131071)  s = 131071;
    if (s < -131072) s = -131072;
    return s;
  endfunction

  function automatic void mdl_push(input int x);
    hist.push_front(x);
    if (hist.size() > NTAPS) hist.delete(NTAPS);
  endfunction

  function automatic void mdl_reset();
    hist.delete();
    for (int i = 0; i < NTAPS; i++) mcoef[i] = 0;
  endfunction

  function automatic int rnd18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic wcoef(input int a, input int d);
    coef_we = 1'b1; coef_addr = AW'(a); coef_data = 18'(d);
    @(posedge CLK0); #1;
    coef_we = 1'b0;
    mcoef[a] = d;
  endtask

  // One sample through the filter with out_ready high; optional coefficient write on the accept edge
  task automatic push(input int x, input bit wr, input int wa, input int wd, output int got);
    int n = 0;
    longint exp;
    while (!in_ready && n < 60) begin @(posedge CLK0); #1; n++; end
    if (!in_ready) begin total++; $display("FAIL in_ready_timeout: got 0, expected 1"); end
    in_data = 18'(x); in_valid = 1'b1;
    if (wr) begin coef_we = 1'b1; coef_addr = AW'(wa); coef_data = 18'(wd); end
    @(posedge CLK0); #1;
    in_valid = 1'b0; coef_we = 1'b0;
    if (wr) mcoef[wa] = wd;
    mdl_push(x);
    exp = mdl_result();
    n = 0;
    while (!out_valid && n < 60) begin @(posedge CLK0); #1; n++; end
    got = out_data;
    if (!out_valid) begin total++; $display("FAIL out_valid_timeout: got 0, expected 1"); end
    else chk("model_out", got, exp);
    @(posedge CLK0); #1;
  endtask

  task automatic stream_test();
    int acc_e[$];
    int ov_e[$];
    int exp_q[$];
    int low_cnt = 0;
    bit prev_ov = 1'b0;
    bit will;
    int xv;
    in_valid = 1'b1;
    for (int e = 1; e <= 3*(NTAPS+3); e++) begin
      xv = rnd18();
      in_data = 18'(xv);
      will = in_ready;
      @(posedge CLK0); #1;
      if (will) begin
        acc_e.push_back(e);
        mdl_push(xv);
        exp_q.push_back(int'(mdl_result()));
      end
      if (!in_ready) low_cnt++;
      if (out_valid && !prev_ov) begin
        ov_e.push_back(e);
        if (exp_q.size() > 0) chk("stream_data", out_data, exp_q.pop_front());
      end
      prev_ov = out_valid;
    end
    in_valid = 1'b0;
    chk("stream_accepts", acc_e.size(), 3);
    chk("stream_outputs", ov_e.size(), 3);
    chk("in_ready_low_cycles", low_cnt, 3*(NTAPS+2));
    if (acc_e.size() >= 3) begin
      chk("throughput_0", acc_e[1] - acc_e[0], NTAPS+3);
      chk("throughput_1", acc_e[2] - acc_e[1], NTAPS+3);
    end
    // out_valid is registered by edge a+NTAPS+1, i.e. presented to the consumer at edge a+NTAPS+2
    if (ov_e.size() >= 1 && acc_e.size() >= 1)
      chk("latency", ov_e[0] - acc_e[0], NTAPS+1);
  endtask

  task automatic backpressure_test();
    int n = 0;
    int bad = 0;
    longint exp;
    logic signed [17:0] d0;
    out_ready = 1'b0;
    in_data = 18'(1000); in_valid = 1'b1;
    @(posedge CLK0); #1;
    in_valid = 1'b0;
    mdl_push(1000);
    exp = mdl_result();
    repeat (3) @(posedge CLK0);
    #1;
    coef_we = 1'b1; coef_addr = AW'(1); coef_data = '0;
    @(posedge CLK0); #1;
    coef_we = 1'b0;
    while (!out_valid && n < 60) begin @(posedge CLK0); #1; n++; end
    chk("bp_out_valid", out_valid, 1);
    d0 = out_data;
    chk("bp_data", d0, exp);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin coef_we = 1'b1; coef_addr = '0; coef_data = '0; end
      @(posedge CLK0); #1;
      coef_we = 1'b0;
      if (!out_valid || out_data != d0 || in_ready) bad++;
    end
    chk("bp_stable_cycles_bad", bad, 0);
    out_ready = 1'b1;
    @(posedge CLK0); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
  endtask

  task automatic reset_mid_run();
    int seen = 0;
    int got;
    in_data = 18'(32); in_valid = 1'b1;
    @(posedge CLK0); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge CLK0);
    #1;
    chk("rst_busy_before", busy, 1);
    #2 RST0_N = 1'b0;
    #1;
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge CLK0);
    #1 RST0_N = 1'b1;
    mdl_reset();
    for (int i = 0; i < 25; i++) begin
      @(posedge CLK0); #1;
      if (out_valid) seen++;
    end
    chk("rst_no_out_valid", seen, 0);
    push(32, 1'b0, 0, 0, got);
    chk("rst_impulse_0", got, 0);
    push(0, 1'b0, 0, 0, got);
    chk("rst_impulse_1", got, 0);
    wcoef(0, 4096);
    wcoef(1, 8192);
    push(32, 1'b0, 0, 0, got);
    push(0, 1'b0, 0, 0, got);
  endtask

  typedef struct {
    int din;
    int dout;
  } vec_t;

  vec_t tbl[NTAPS+1];

  initial begin
    int got;
    RST0_N = 1'b0; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0; out_ready = 1'b1;
    mdl_reset();

    // Impulse response: 32 * (k+1)*4096 / 2^17 = k+1 exactly; entry NTAPS has wrapped out of the line
    tbl[0] = '{32, 1};
    for (int i = 1; i < NTAPS; i++) tbl[i] = '{0, i + 1};
    tbl[NTAPS] = '{0, 0};

    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_mult_a", mult_a, 0);
    chk("reset_mult_b", mult_b, 0);
    @(posedge CLK0); #2;
    RST0_N = 1'b1;
    #1 chk("in_ready_before_edge", in_ready, 0);
    @(posedge CLK0); #1;
    chk("in_ready_after_edge", in_ready, 1);

    for (int i = 0; i < NTAPS; i++) wcoef(i, (i + 1) * 4096);
    for (int i = 0; i <= NTAPS; i++) begin
      push(tbl[i].din, 1'b0, 0, 0, got);
      chk($sformatf("impulse_%0d", i), got, tbl[i].dout);
    end

    stream_test();
    backpressure_test();
    push(32, 1'b0, 0, 0, got);
    push(0, 1'b0, 0, 0, got);

    // Coefficient written on the accept edge applies to that sample
    push(32, 1'b1, 0, 131071, got);

    wcoef(0, 65536);
    for (int i = 1; i < NTAPS; i++) wcoef(i, 0);
    push(3, 1'b0, 0, 0, got);
    chk("round_pos", got, ROUND ? 2 : 1);
    push(-3, 1'b0, 0, 0, got);
    chk("round_neg", got, ROUND ? -1 : -2);

    for (int i = 0; i < NTAPS; i++) wcoef(i, 131071);
    for (int i = 0; i < NTAPS; i++) push(131071, 1'b0, 0, 0, got);
    chk("sat_pos", got, 131071);
    for (int i = 0; i < NTAPS; i++) push(-131072, 1'b0, 0, 0, got);
    chk("sat_neg", got, -131072);

    for (int i = 0; i < NTAPS; i++) wcoef(i, rnd18());
    for (int i = 0; i < 24; i++)
      push(rnd18(), ($urandom_range(0, 3) == 0), int'($urandom_range(0, NTAPS-1)), rnd18(), got);

    for (int i = 0; i < NTAPS; i++) wcoef(i, (i + 1) * 4096);
    reset_mid_run();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
- Time-multiplexed FIR sequencer/accumulator wrapped around one MULT18X18D instance.
- Accepts one 18-bit signed sample per handshake, stores it in a circular delay line, and issues NTAPS sample/coefficient pairs to the multiplier, one per cycle.
- Accumulates the registered 36-bit products, then rounds, shifts and saturates the sum to an 18-bit output stream.
- Sits between the SDR front-end sample stream and the demod path; it is the upstream feeder and the downstream consumer of the multiplier.

Parameters:
- NTAPS, 16: filter length, power of two, 2..64.
- OUT_SHIFT, 17: arithmetic right shift applied to the accumulator (Q17 coefficients).
- ACCW, 42: accumulator width; at least 36+log2(NTAPS).

Ports:
- CLK0  in  1  single clock; the multiplier's CLK0 uses the same net.
- RST0_N  in  1  asynchronous active-low reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_data  in  18  signed sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(NTAPS)  coefficient index.
- coef_data  in  18  signed coefficient.
- mult_a  out  18  to multiplier A.
- mult_b  out  18  to multiplier B.
- mult_p  in  36  from multiplier P; registered, latency 1; multiplier RST0 tied 0.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  18  signed filtered result.
- busy  out  1  high in RUN, DRAIN and OUT.

Behaviour:
- Reset (async, RST0_N=0) clears everything to 0:
  - state=IDLE, wr_ptr, tap counter, accumulator, p_vld, p_first;
  - all delay-line and coefficient registers;
  - mult_a, mult_b, out_valid, out_data, busy.
  - in_ready=1 from the first clock edge after reset release.
- IDLE:
  - in_ready=1, mult_a=mult_b=0.
  - On accept: write in_data to line[wr_ptr], k=0, go RUN.
- RUN, NTAPS cycles:
  - mult_a = line[(wr_ptr-k) mod NTAPS], mult_b = coef[k]; the index wraps modulo NTAPS.
  - Set p_vld, and set p_first for k=0.
  - k increments; after k=NTAPS-1, advance wr_ptr (mod NTAPS) and go DRAIN.
- Accumulation happens one cycle after issue, on p_vld:
  - acc <= p_first ? sext(mult_p) : acc + sext(mult_p).
  - Full-precision two's complement; no internal overflow is possible given ACCW.
- DRAIN, 1 cycle: absorbs the last product; mult_a=mult_b=0; go OUT.
- OUT:
  - out_data = sat18((acc + rnd) >>> OUT_SHIFT), registered on DRAIN exit; out_valid=1.
  - out_data and out_valid stay stable until out_ready; then go IDLE.
  - in_ready=0 throughout RUN, DRAIN and OUT.
- Saturation clamps to [-131072, +131071].
- Latency: accept at edge 0 -> out_valid high after edge NTAPS+2. Throughput is 1 sample per NTAPS+3 cycles when out_ready=1.
- Coefficient writes:
  - Honoured only when busy=0; writes while busy=1 are dropped.
  - A write and a sample accept in the same IDLE cycle are both honoured; the new coefficient applies to that sample.
- Reset mid-RUN/OUT: the in-flight result is discarded; no out_valid pulse.

Optional Feature:
- FIR_MAC_ROUND_EN defined: rnd = 2^(OUT_SHIFT-1) (round half up); when OUT_SHIFT=0, rnd=0.
- FIR_MAC_ROUND_EN undefined: rnd = 0 (truncate toward minus infinity).
- No port change either way.

Decomposition:
- Package fir_mac_pkg holds:
  - DW=18, PW=36, SAT_MAX=131071, SAT_MIN=-131072;
  - state enum {IDLE, RUN, DRAIN, OUT};
  - function sat18.
- One sub-module, fir_mac_rsat: combinational round/shift/saturate of the accumulator to 18 bits; registered by the parent.
- Multiplier is instantiated at the top, outside this block.

Test Plan:
- Impulse, NTAPS=4, OUT_SHIFT=0, coef={1,2,3,4}, inputs 1,0,0,0 -> outputs 1,2,3,4; inputs 5,0,0,0,0 -> 5,10,15,20,0 (delay-line wrap).
- Latency/throughput, NTAPS=16: accept at edge 0 -> out_valid after edge 18; in_ready low edges 1..18; continuous stream with out_ready=1 gives one output every 19 cycles.
- Rounding, OUT_SHIFT=1, coef0=1, others 0: in 3 -> 2 with FIR_MAC_ROUND_EN, 1 without; in -3 -> -1 with, -2 without.
- Saturation, defaults, all coef=131071, 16 samples of 131071 -> out 131071; 16 samples of -131072 -> out -131072.
- Backpressure/coef drop: out_ready=0 for 10 cycles -> out_valid, out_data stable, in_ready=0; coef_we pulse during busy leaves the coefficient unchanged (confirmed by a following impulse).
- Async reset during RUN (k=5): outputs 0 immediately, no out_valid; after release the impulse response is all 0 until coefficients are reloaded.
